// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD step sequencer and its prescaler.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Returns {wrap, next_digit}; out-of-range inputs fold back to 0.
    function automatic logic [BCD_W:0] bcd_step(input logic [BCD_W-1:0] d, input logic up);
        logic [BCD_W:0] r;
        r = {1'b0, 4'd0};
        if (d > BCD_MAX) begin
            r = {1'b0, 4'd0};
        end else if (up) begin
            if (d == BCD_MAX) begin
                r = {1'b1, 4'd0};
            end else begin
                r = {1'b0, d + 4'd1};
            end
        end else begin
            if (d == 4'd0) begin
                r = {1'b1, BCD_MAX};
            end else begin
                r = {1'b0, d - 4'd1};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that raises tick once every TICK_DIV cycles while run is high.
module tick_prescaler #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == CNT_LAST);

    // Next count: clear wins, then wrap on the tick, otherwise advance while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (tick) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_step_sequencer.sv
// BCD digit source for the one-hot decoder: steps 0..9 up/down at a prescaled rate
// with start/stop/hold control, parallel load and single-sweep mode.
module bcd_step_sequencer
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             single,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] digit,
    output logic             dec_en,
    output logic             wrap,
    output logic             busy,
    output logic             load_err
);

    state_e           state_q,    state_d;
    logic [BCD_W-1:0] digit_q,    digit_d;
    logic             dec_en_q,   dec_en_d;
    logic             wrap_q,     wrap_d;
    logic             busy_q,     busy_d;
    logic             load_err_q, load_err_d;

    logic             tick_s;
    logic             load_ok_s;
    logic             step_s;
    logic             clr_s;
    logic [BCD_W:0]   stepped_s;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == RUN),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Digit update, state transitions and next values of the registered outputs.
    always_comb begin
        load_ok_s  = load && (load_val <= BCD_MAX);
        load_err_d = load && (load_val > BCD_MAX);
        // A valid load swallows a coincident tick, so no wrap can come from it.
        step_s     = tick_s && !load_ok_s;
        stepped_s  = bcd_step(digit_q, dir);
        digit_d    = digit_q;
        wrap_d     = 1'b0;
        if (load_ok_s) begin
            digit_d = load_val;
        end else if (step_s) begin
            digit_d = stepped_s[BCD_W-1:0];
            wrap_d  = stepped_s[BCD_W];
        end else begin
            digit_d = digit_q;
        end

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HOLD;
                end else if (wrap_d && single) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        clr_s    = load_ok_s || ((state_d == RUN) && (state_q != RUN));
        dec_en_d = (state_d != IDLE);
        busy_d   = (state_d == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            digit_q    <= 4'd0;
            dec_en_q   <= 1'b0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            dec_en_q   <= dec_en_d;
            wrap_q     <= wrap_d;
            busy_q     <= busy_d;
            load_err_q <= load_err_d;
        end
    end

    assign digit    = digit_q;
    assign dec_en   = dec_en_q;
    assign wrap     = wrap_q;
    assign busy     = busy_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_step_sequencer.sv
// Scoreboard bench for bcd_step_sequencer with TICK_DIV = 4: a behavioural model
// predicts every cycle's outputs, and each scenario adds targeted checks.
module tb_bcd_step_sequencer;
    import bcd_pkg::*;

    localparam int TICK_DIV = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       dir      = 1'b1;
    logic       single   = 1'b0;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] digit;
    logic       dec_en;
    logic       wrap;
    logic       busy;
    logic       load_err;

    typedef struct packed {
        logic [3:0] digit;
        logic       dec_en;
        logic       wrap;
        logic       busy;
        logic       load_err;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    state_e     m_state = IDLE;
    int         m_cnt = 0;
    logic [3:0] m_digit = 4'd0;

    bcd_step_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .single   (single),
        .load     (load),
        .load_val (load_val),
        .digit    (digit),
        .dec_en   (dec_en),
        .wrap     (wrap),
        .busy     (busy),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    // Predict the outputs that the next rising edge must produce from the driven inputs.
    task automatic model_push();
        exp_t       e;
        logic       tk, lok, wr;
        logic [3:0] nd;
        state_e     ns;
        if (!rst_n) begin
            m_state = IDLE;
            m_cnt   = 0;
            m_digit = 4'd0;
            e       = '0;
        end else begin
            tk  = (m_state == RUN) && (m_cnt == TICK_DIV - 1);
            lok = load && (load_val <= 4'd9);
            wr  = 1'b0;
            nd  = m_digit;
            if (lok) begin
                nd = load_val;
            end else if (tk) begin
                if (dir) begin
                    if (m_digit == 4'd9) begin nd = 4'd0; wr = 1'b1; end
                    else nd = m_digit + 4'd1;
                end else begin
                    if (m_digit == 4'd0) begin nd = 4'd9; wr = 1'b1; end
                    else nd = m_digit - 4'd1;
                end
            end
            ns = m_state;
            if (m_state == IDLE) begin
                if (start && !stop) ns = RUN;
            end else if (m_state == RUN) begin
                if (stop || (wr && single)) ns = HOLD;
            end else begin
                if (stop) ns = IDLE;
                else if (start) ns = RUN;
            end
            if (lok || (ns == RUN && m_state != RUN)) m_cnt = 0;
            else if (m_state == RUN) m_cnt = tk ? 0 : m_cnt + 1;
            m_state    = ns;
            m_digit    = nd;
            e.digit    = nd;
            e.dec_en   = (ns != IDLE);
            e.wrap     = wr;
            e.busy     = (ns == RUN);
            e.load_err = load && (load_val > 4'd9);
        end
        exp_q.push_back(e);
    endtask

    task automatic run_cycle();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({digit, dec_en, wrap, busy, load_err} !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got digit=%0d en=%b wrap=%b busy=%b lerr=%b, want digit=%0d en=%b wrap=%b busy=%b lerr=%b",
                     $time, digit, dec_en, wrap, busy, load_err, e.digit, e.dec_en, e.wrap, e.busy, e.load_err);
        end
        checks++;
        if ($isunknown(digit) || digit > 4'd9) begin
            errors++;
            $display("FAIL digit_range t=%0t got %0d want 0..9", $time, digit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run_cycle();
        run_cycle();
        checks++;
        if ({digit, dec_en, wrap, busy, load_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %h want 00", {digit, dec_en, wrap, busy, load_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        dir = 1'b1; single = 1'b0;
        start = 1'b1; run_cycle(); start = 1'b0;
        checks++;
        if (dec_en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL start_enables got en=%b busy=%b want 1 1", dec_en, busy);
        end
        repeat (3) run_cycle();
        checks++;
        if (digit !== 4'd0) begin errors++; $display("FAIL pre_first_step got %0d want 0", digit); end
        run_cycle();
        checks++;
        if (digit !== 4'd1) begin errors++; $display("FAIL first_step got %0d want 1", digit); end
        repeat (32) run_cycle();
        checks++;
        if (digit !== 4'd9) begin errors++; $display("FAIL count_to_9 got %0d want 9", digit); end
        repeat (4) run_cycle();
        checks++;
        if (digit !== 4'd0 || wrap !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL wrap_up got digit=%0d wrap=%b busy=%b want 0 1 1", digit, wrap, busy);
        end
        run_cycle();
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle got %b want 0", wrap); end
    endtask

    task automatic test_single_down();
        load = 1'b1; load_val = 4'd0; run_cycle(); load = 1'b0;
        dir = 1'b0; single = 1'b1;
        repeat (3) run_cycle();
        checks++;
        if (digit !== 4'd0) begin errors++; $display("FAIL down_pre_step got %0d want 0", digit); end
        run_cycle();
        checks++;
        if (digit !== 4'd9 || wrap !== 1'b1 || busy !== 1'b0 || dec_en !== 1'b1) begin
            errors++; $display("FAIL single_down_wrap got digit=%0d wrap=%b busy=%b en=%b want 9 1 0 1", digit, wrap, busy, dec_en);
        end
        repeat (20) run_cycle();
        checks++;
        if (digit !== 4'd9 || busy !== 1'b0 || dec_en !== 1'b1) begin
            errors++; $display("FAIL single_hold got digit=%0d busy=%b en=%b want 9 0 1", digit, busy, dec_en);
        end
    endtask

    task automatic test_load();
        single = 1'b0; dir = 1'b1;
        load = 1'b1; load_val = 4'd3; run_cycle(); load = 1'b0;
        start = 1'b1; run_cycle(); start = 1'b0;
        repeat (2) run_cycle();
        load = 1'b1; load_val = 4'd7; run_cycle(); load = 1'b0;
        checks++;
        if (digit !== 4'd7) begin errors++; $display("FAIL load_valid got %0d want 7", digit); end
        repeat (3) run_cycle();
        checks++;
        if (digit !== 4'd7) begin errors++; $display("FAIL load_hold got %0d want 7", digit); end
        run_cycle();
        checks++;
        if (digit !== 4'd8) begin errors++; $display("FAIL step_after_load got %0d want 8", digit); end
        load = 1'b1; load_val = 4'd12; run_cycle(); load = 1'b0;
        checks++;
        if (load_err !== 1'b1 || digit !== 4'd8) begin
            errors++; $display("FAIL load_err_pulse got lerr=%b digit=%0d want 1 8", load_err, digit);
        end
        run_cycle();
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_one_cycle got %b want 0", load_err); end
    endtask

    task automatic test_stop_hold();
        stop = 1'b1; run_cycle(); stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || dec_en !== 1'b1) begin
            errors++; $display("FAIL stop_to_hold got busy=%b en=%b want 0 1", busy, dec_en);
        end
        repeat (20) run_cycle();
        checks++;
        if (digit !== 4'd8) begin errors++; $display("FAIL hold_frozen got %0d want 8", digit); end
        start = 1'b1; run_cycle(); start = 1'b0;
        repeat (3) run_cycle();
        checks++;
        if (digit !== 4'd8) begin errors++; $display("FAIL resume_wait got %0d want 8", digit); end
        run_cycle();
        checks++;
        if (digit !== 4'd9) begin errors++; $display("FAIL resume_step got %0d want 9", digit); end
        stop = 1'b1; run_cycle(); run_cycle(); stop = 1'b0;
        checks++;
        if (dec_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stop_to_idle got en=%b busy=%b want 0 0", dec_en, busy);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; stop = 1'b1; run_cycle();
        checks++;
        if (dec_en !== 1'b0) begin errors++; $display("FAIL idle_stop_wins got en=%b want 0", dec_en); end
        stop = 1'b0; run_cycle();
        stop = 1'b1; run_cycle(); start = 1'b0;
        checks++;
        if (busy !== 1'b0 || dec_en !== 1'b1) begin
            errors++; $display("FAIL run_stop_wins got busy=%b en=%b want 0 1", busy, dec_en);
        end
        run_cycle(); stop = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; run_cycle(); start = 1'b0;
        load = 1'b1; load_val = 4'd5; run_cycle(); load = 1'b0;
        repeat (2) run_cycle();
        rst_n = 1'b0; run_cycle();
        checks++;
        if (digit !== 4'd0 || dec_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_run got digit=%0d en=%b busy=%b want 0 0 0", digit, dec_en, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_tick();
        dir = 1'b1; single = 1'b0;
        start = 1'b1; run_cycle(); start = 1'b0;
        load = 1'b1; load_val = 4'd9; run_cycle(); load = 1'b0;
        repeat (3) run_cycle();
        load = 1'b1; load_val = 4'd4; run_cycle(); load = 1'b0;
        checks++;
        if (digit !== 4'd4 || wrap !== 1'b0) begin
            errors++; $display("FAIL load_beats_tick got digit=%0d wrap=%b want 4 0", digit, wrap);
        end
        repeat (3) run_cycle();
        run_cycle();
        checks++;
        if (digit !== 4'd5) begin errors++; $display("FAIL step_after_collision got %0d want 5", digit); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom % 8) == 0;
            stop     = ($urandom % 12) == 0;
            dir      = $urandom % 2;
            single   = ($urandom % 4) == 0;
            load     = ($urandom % 10) == 0;
            load_val = 4'($urandom_range(0, 11));
            run_cycle();
        end
        start = 1'b0; stop = 1'b0; load = 1'b0; single = 1'b0;
        run_cycle();
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_single_down();
        test_load();
        test_stop_hold();
        test_back_to_back();
        test_reset_mid_run();
        test_load_tick();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_step_sequencer.md
Name: bcd_step_sequencer

Overview:
- Upstream digit source for the 4-to-10 one-hot decoder stage: generates a BCD digit (0..9) plus a decoder enable.
- Steps the digit up or down at a programmable rate, with start/stop/hold control, parallel load, and single-sweep mode.
- digit and dec_en connect directly to the decoder's in and en inputs.
- Codes 10..15 are never emitted.

Parameters:
- TICK_DIV, 4, clock cycles per digit step; legal range 2..65535.
- CNT_W, 16, prescaler counter width; must satisfy 2**CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; starts or resumes stepping.
- stop  input  1  one-cycle pulse; pauses, or returns to idle from HOLD.
- dir  input  1  1 = count up, 0 = count down; sampled on each step tick.
- single  input  1  1 = stop after one wrap; sampled on each step tick.
- load  input  1  one-cycle pulse; loads load_val.
- load_val  input  4  value to load; must be 0..9.
- digit  output  4  current BCD digit; drives the decoder's in.
- dec_en  output  1  decoder enable; drives the decoder's en.
- wrap  output  1  one-cycle pulse on a 9->0 or 0->9 step.
- busy  output  1  high while in RUN.
- load_err  output  1  one-cycle pulse when load_val > 9.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: digit = 0, dec_en = 0, wrap = 0, busy = 0, load_err = 0, state = IDLE, prescaler = 0. Reset takes effect at the first clk edge with rst_n low, including mid-RUN.
- All outputs are registered.
- States:
  - IDLE: dec_en = 0, busy = 0.
  - RUN: dec_en = 1, busy = 1.
  - HOLD: dec_en = 1, busy = 0.
- Transitions:
  - IDLE, start -> RUN.
  - RUN, stop -> HOLD.
  - RUN, step tick with wrap and single = 1 -> HOLD.
  - HOLD, start -> RUN.
  - HOLD, stop -> IDLE.
  - All other inputs: stay in the current state.
  - start and stop in the same cycle: stop wins.
- Prescaler:
  - Runs only in RUN and counts 0..TICK_DIV-1.
  - The step tick fires in the cycle the count equals TICK_DIV-1; the count then returns to 0.
  - Cleared to 0 on every entry into RUN and on every accepted load.
  - First step occurs TICK_DIV cycles after the start edge.
- Step:
  - Up: digit + 1, with 9 -> 0 asserting wrap.
  - Down: digit - 1, with 0 -> 9 asserting wrap.
  - wrap is high in the same cycle the wrapped digit first appears.
  - No step occurs outside RUN.
- Load (all states):
  - load_val <= 9: digit <= load_val on the next edge and the prescaler clears.
  - load_val > 9: digit unchanged, prescaler unchanged, load_err pulses for one cycle.
  - Load does not change state.
  - A load and a tick in the same cycle: the load wins and the tick is dropped, with no wrap.
- Invariant: digit is always in 0..9. Assert this in the bench.
- Single mode: after the wrap, digit holds the wrapped value (0 going up, 9 going down) in HOLD.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum {IDLE, RUN, HOLD};
  - BCD_MAX = 4'd9;
  - BCD_W = 4.
- One natural sub-module, tick_prescaler: parameters TICK_DIV and CNT_W; inputs clk, rst_n, run, clr; output tick.

Test Plan (TICK_DIV = 4):
- Hold rst_n low for 2 cycles -> all outputs 0. Pulse start with dir = 1 -> dec_en = 1 and busy = 1 the next cycle; digit goes 1, 2, ... every 4 cycles.
- Count up to 9, then step again -> digit = 0 with wrap high for exactly that one cycle; counting continues.
- Load 0, dir = 0, step -> digit = 9 with a wrap pulse. With single = 1 -> state HOLD, busy = 0, dec_en = 1, digit stays 9.
- In RUN at digit = 3, load 7 -> digit = 7 on the next cycle and the next step 4 cycles later (8). Load 12 -> load_err pulses once and digit is unchanged.
- stop in RUN -> HOLD with digit frozen for 20 cycles. start -> resumes with the first step 4 cycles later. Two stops from RUN -> IDLE, dec_en = 0.
- rst_n low mid-RUN at digit = 5 -> next edge: digit = 0, dec_en = 0, IDLE. A load and a tick in the same cycle -> digit = load_val and no wrap.
